// File: rtl/sched_pkg.sv
// Shared types and helpers for the round-robin task scheduler.
// Build option: define SCHED_BCD_CNT_EN to make the dispatch counter a
// 4-digit packed BCD counter (0000..9999) instead of a 16-bit binary one.
package sched_pkg;

  localparam int TASK_ID_W = 4;
  localparam int TIMER_W   = 4;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_RUN
  } sched_state_t;

  // Result of one round-robin search over the ready mask.
  typedef struct packed {
    logic                 hit;
    logic [TASK_ID_W-1:0] idx;
  } rr_pick_t;

  // Next value of the dispatch counter; both encodings wrap silently.
  function automatic logic [CNT_W-1:0] switch_cnt_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt;
`ifdef SCHED_BCD_CNT_EN
    logic carry;
    nxt   = cnt;
    carry = 1'b1;
    for (int d = 0; d < CNT_W / 4; d++) begin
      if (carry) begin
        if (nxt[d*4 +: 4] == 4'd9) begin
          nxt[d*4 +: 4] = 4'd0;
        end else begin
          nxt[d*4 +: 4] = nxt[d*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
`else
    nxt = cnt + CNT_W'(1);
`endif
    return nxt;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick prescaler: counts 0..TICK_DIV-1 and emits a registered
// one-cycle pulse each time it wraps. Held at zero while disabled.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iEN,
  output logic oTICK
);

  localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divide the clock down to scheduler ticks.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt   <= '0;
      oTICK <= 1'b0;
    end else if (!iEN) begin
      cnt   <= '0;
      oTICK <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      oTICK <= 1'b1;
    end else begin
      cnt   <= cnt + CNT_W'(1);
      oTICK <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_task_scheduler.sv
// Round-robin time-slice task scheduler (IDLE -> SELECT -> RUN).
// SELECT searches the ready mask starting one past the last-run task; RUN
// counts the slice down on prescaler ticks and leaves early on yield or when
// the running task drops its ready bit.
// Build option: SCHED_BCD_CNT_EN selects a BCD dispatch counter.
module rr_task_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_TASKS   = 8,
  parameter int SLICE_TICKS = 9,
  parameter int TICK_DIV    = 50000000
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iEN,
  input  logic [NUM_TASKS-1:0] iREADY,
  input  logic                 iYIELD,
  output logic [TASK_ID_W-1:0] oTASK_ID,
  output logic [TIMER_W-1:0]   oTASK_TIMER,
  output logic [CNT_W-1:0]     oSWITCH_CNT,
  output logic                 oRUNNING,
  output logic                 oTICK
);

  localparam int                   READY_EXT_W = 1 << TASK_ID_W;
  localparam logic [TASK_ID_W-1:0] ID_LAST     = TASK_ID_W'(NUM_TASKS - 1);
  localparam logic [TIMER_W-1:0]   SLICE_LOAD  = TIMER_W'(SLICE_TICKS);
  localparam logic [TIMER_W-1:0]   TIMER_ONE   = TIMER_W'(1);

  sched_state_t           state;
  logic [CNT_W-1:0]       switch_cnt;
  logic [READY_EXT_W-1:0] ready_ext;
  rr_pick_t               pick;

  // Zero-padded to the full task-id range so any id indexes it safely.
  assign ready_ext   = READY_EXT_W'(iREADY);
  assign oSWITCH_CNT = switch_cnt;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .iCLK (iCLK),
    .iRST (iRST),
    .iEN  (iEN),
    .oTICK(oTICK)
  );

  // First ready task after `last`, wrapping; `last` itself is tried last so a
  // lone ready task gets re-dispatched.
  function automatic rr_pick_t rr_search(input logic [READY_EXT_W-1:0] ready,
                                         input logic [TASK_ID_W-1:0]   last);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int i = 1; i <= NUM_TASKS; i++) begin
      cand = int'(last) + i;
      if (cand >= NUM_TASKS) cand = cand - NUM_TASKS;
      if (!res.hit && ready[cand[TASK_ID_W-1:0]]) begin
        res.hit = 1'b1;
        res.idx = TASK_ID_W'(cand);
      end
    end
    return res;
  endfunction

  // Candidate for the next dispatch, evaluated every cycle.
  always_comb begin
    pick = rr_search(ready_ext, oTASK_ID);
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= ST_IDLE;
      oTASK_ID    <= ID_LAST;
      oTASK_TIMER <= '0;
      switch_cnt  <= '0;
      oRUNNING    <= 1'b0;
    end else if (!iEN) begin
      state       <= ST_IDLE;
      oTASK_TIMER <= '0;
      oRUNNING    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          oTASK_TIMER <= '0;
          oRUNNING    <= 1'b0;
          if (|iREADY) state <= ST_SELECT;
        end
        ST_SELECT: begin
          if (pick.hit) begin
            oTASK_ID    <= pick.idx;
            oTASK_TIMER <= SLICE_LOAD;
            switch_cnt  <= switch_cnt_inc(switch_cnt);
            oRUNNING    <= 1'b1;
            state       <= ST_RUN;
          end else begin
            oTASK_TIMER <= '0;
            oRUNNING    <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Yield and lost-ready are checked first so a coincident tick
          // leaves the timer untouched.
          if (iYIELD || !ready_ext[oTASK_ID]) begin
            oRUNNING <= 1'b0;
            state    <= ST_SELECT;
          end else if (oTICK) begin
            oTASK_TIMER <= oTASK_TIMER - TIMER_ONE;
            if (oTASK_TIMER == TIMER_ONE) begin
              oRUNNING <= 1'b0;
              state    <= ST_SELECT;
            end
          end
        end
        default: begin
          oTASK_TIMER <= '0;
          oRUNNING    <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_task_scheduler.sv
// Self-checking bench for rr_task_scheduler (NUM_TASKS=8, SLICE_TICKS=3,
// TICK_DIV=4). A cycle-exact vector table covers the first slices after
// reset; a dispatch scoreboard checks task order and counter values; short
// hand-written sequences cover yield, ready loss, reset and counter wrap.
module tb_rr_task_scheduler;

  localparam int NT = 8;
  localparam int SL = 3;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [NT-1:0] ready;
  logic          yield;
  logic [3:0]    task_id;
  logic [3:0]    task_timer;
  logic [15:0]   switch_cnt;
  logic          running;
  logic          tick;

  always #5 clk = ~clk;

  rr_task_scheduler #(
    .NUM_TASKS  (NT),
    .SLICE_TICKS(SL),
    .TICK_DIV   (TD)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iEN        (en),
    .iREADY     (ready),
    .iYIELD     (yield),
    .oTASK_ID   (task_id),
    .oTASK_TIMER(task_timer),
    .oSWITCH_CNT(switch_cnt),
    .oRUNNING   (running),
    .oTICK      (tick)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent counter model: decimal arithmetic for BCD, plain add otherwise.
  function automatic logic [15:0] model_inc(input logic [15:0] v);
`ifdef SCHED_BCD_CNT_EN
    int dec;
    dec = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    dec = (dec + 1) % 10000;
    return {4'(dec / 1000), 4'((dec / 100) % 10), 4'((dec / 10) % 10), 4'(dec % 10)};
`else
    return v + 16'd1;
`endif
  endfunction

  // Dispatch scoreboard.
  typedef struct {
    logic [3:0]  id;
    logic [15:0] cnt;
  } disp_t;

  disp_t       exp_q[$];
  logic [15:0] model_cnt  = '0;
  logic [15:0] prev_cnt   = '0;
  logic        mon_en     = 1'b0;
  logic [15:0] preload_val;

  task automatic push_disp(input logic [3:0] id);
    disp_t d;
    model_cnt = model_inc(model_cnt);
    d.id      = id;
    d.cnt     = model_cnt;
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Every change of the switch counter is a dispatch and must match the queue.
  initial begin : monitor
    disp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && switch_cnt !== prev_cnt) begin
        if (exp_q.size() == 0) begin
          check("spurious_dispatch", switch_cnt, prev_cnt);
        end else begin
          e = exp_q.pop_front();
          check("dispatch", {task_id, task_timer, running, switch_cnt},
                {e.id, 4'(SL), 1'b1, e.cnt});
        end
      end
      prev_cnt = switch_cnt;
    end
  end

  task automatic preload_and_dispatch(input logic [15:0] v, input logic [15:0] want,
                                      input string name);
    mon_en      = 1'b0;
    preload_val = v;
    force dut.switch_cnt = preload_val;
    #1;
    release dut.switch_cnt;
    model_cnt = v;
    @(negedge clk);
    mon_en = 1'b1;
    en     = 1'b1;
    ready  = 8'h01;
    push_disp(4'd0);
    wait_drain(8, {name, "_drain"});
    check(name, switch_cnt, want);
    en = 1'b0;
    @(negedge clk);
  endtask

  // Cycle-exact vectors: inputs applied before an edge, outputs seen after it.
  typedef struct {
    logic        en;
    logic [7:0]  ready;
    logic        yield;
    logic [3:0]  id;
    logic [3:0]  timer;
    logic        running;
    logic        tick;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[14];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic found;

    vecs[0]  = '{1'b1, 8'h05, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 16'd1};
    vecs[2]  = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd3, 1'b1, 1'b0, 16'd1};
    vecs[3]  = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd3, 1'b1, 1'b1, 16'd1};
    vecs[4]  = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 16'd1};
    vecs[5]  = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 16'd1};
    vecs[6]  = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 16'd1};
    vecs[7]  = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd2, 1'b1, 1'b1, 16'd1};
    vecs[8]  = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 16'd1};
    vecs[9]  = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 16'd1};
    vecs[10] = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 16'd1};
    vecs[11] = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd1, 1'b1, 1'b1, 16'd1};
    vecs[12] = '{1'b1, 8'h05, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 16'd1};
    vecs[13] = '{1'b1, 8'h05, 1'b0, 4'd2, 4'd3, 1'b1, 1'b0, 16'd2};

    rst   = 1'b1;
    en    = 1'b0;
    ready = '0;
    yield = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {task_id, task_timer, running, tick, switch_cnt},
          {4'd7, 4'd0, 1'b0, 1'b0, 16'd0});
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Dispatch order 0,2,0,2 with 12-cycle slices.
    push_disp(4'd0);
    push_disp(4'd2);
    push_disp(4'd0);
    push_disp(4'd2);
    for (int i = 0; i < 14; i++) begin
      en    = vecs[i].en;
      ready = vecs[i].ready;
      yield = vecs[i].yield;
      @(negedge clk);
      check($sformatf("vec%0d", i), {task_id, task_timer, running, tick, switch_cnt},
            {vecs[i].id, vecs[i].timer, vecs[i].running, vecs[i].tick, vecs[i].cnt});
    end
    wait_drain(60, "slice_order");

    // Disable mid-slice: timer cleared, id held, no count.
    en = 1'b0;
    @(negedge clk);
    check("en_off_hold", {task_id, task_timer, running, tick, switch_cnt},
          {4'd2, 4'd0, 1'b0, 1'b0, model_cnt});

    // Only task 7 ready: wrap search reselects it and still counts.
    en    = 1'b1;
    ready = 8'h80;
    push_disp(4'd7);
    push_disp(4'd7);
    wait_drain(40, "wrap_reselect");
    en = 1'b0;
    @(negedge clk);

    // Yield coinciding with a tick while task 2 runs with timer 2.
    en    = 1'b1;
    ready = 8'h05;
    push_disp(4'd0);
    push_disp(4'd2);
    push_disp(4'd0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (tick && running && task_id == 4'd2 && task_timer == 4'd2) found = 1'b1;
    end
    check("yield_setup", 32'(found), 32'd1);
    yield = 1'b1;
    @(negedge clk);
    yield = 1'b0;
    check("yield_tick", {task_id, task_timer, running}, {4'd2, 4'd2, 1'b0});
    wait_drain(8, "yield_next");

    // Asynchronous reset in the middle of task 0's slice.
    @(negedge clk);
    mon_en = 1'b0;
    en     = 1'b0;
    ready  = '0;
    #2 rst = 1'b1;
    #1;
    check("async_reset", {task_id, task_timer, running, tick, switch_cnt},
          {4'd7, 4'd0, 1'b0, 1'b0, 16'd0});
    @(negedge clk);
    rst       = 1'b0;
    model_cnt = '0;
    @(negedge clk);
    mon_en = 1'b1;
    en     = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {task_timer, running, switch_cnt}, {4'd0, 1'b0, 16'd0});

    // Two-cycle dispatch latency from ready rising in IDLE.
    ready = 8'h04;
    push_disp(4'd2);
    @(negedge clk);
    check("latency_1", 32'(running), 32'd0);
    @(negedge clk);
    check("latency_2", {task_id, running}, {4'd2, 1'b1});

    // Running task drops ready: SELECT next edge, then the other task.
    @(negedge clk);
    ready = 8'h01;
    push_disp(4'd0);
    @(negedge clk);
    check("drop_select", 32'(running), 32'd0);
    wait_drain(4, "drop_redispatch");

    // All ready bits drop: SELECT, then IDLE with timer cleared.
    ready = 8'h00;
    @(negedge clk);
    check("zero_select", 32'(running), 32'd0);
    @(negedge clk);
    check("zero_idle", {task_timer, running}, {4'd0, 1'b0});
    repeat (4) @(negedge clk);
    check("zero_no_switch", switch_cnt, model_cnt);

    // Enable dropped mid-RUN.
    ready = 8'h01;
    push_disp(4'd0);
    wait_drain(6, "reselect_zero");
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_off_run", {task_id, task_timer, running, tick, switch_cnt},
          {4'd0, 4'd0, 1'b0, 1'b0, model_cnt});

    // Counter wrap and carry from a preloaded value.
`ifdef SCHED_BCD_CNT_EN
    preload_and_dispatch(16'h9999, 16'h0000, "bcd_wrap");
    preload_and_dispatch(16'h0009, 16'h0010, "bcd_carry");
`else
    preload_and_dispatch(16'hFFFF, 16'h0000, "bin_wrap");
    preload_and_dispatch(16'h00FF, 16'h0100, "bin_carry");
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
